// File: rtl/cofi_ctrl_if.sv
// Video-timing / config / status bundle for the composite-blend controller.
//   master : video timing source plus OSD/config side (drives pix_ce, hblank,
//            vblank, mode; observes enable, frame_valid, h_active, v_active)
//   slave  : cofi_ctrl itself
// Optional status signals frame_cnt/en_changed exist only when
// COFI_CTRL_STATUS_EN is defined.
interface cofi_ctrl_if #(
  parameter int unsigned HCNT_W = 10,
  parameter int unsigned VCNT_W = 10
);
  logic              pix_ce;
  logic              hblank;
  logic              vblank;
  logic [1:0]        mode;
  logic              enable;
  logic              frame_valid;
  logic [HCNT_W-1:0] h_active;
  logic [VCNT_W-1:0] v_active;
`ifdef COFI_CTRL_STATUS_EN
  logic [7:0]        frame_cnt;
  logic              en_changed;

  modport master (
    output pix_ce, hblank, vblank, mode,
    input  enable, frame_valid, h_active, v_active, frame_cnt, en_changed
  );

  modport slave (
    input  pix_ce, hblank, vblank, mode,
    output enable, frame_valid, h_active, v_active, frame_cnt, en_changed
  );
`else
  modport master (
    output pix_ce, hblank, vblank, mode,
    input  enable, frame_valid, h_active, v_active
  );

  modport slave (
    input  pix_ce, hblank, vblank, mode,
    output enable, frame_valid, h_active, v_active
  );
`endif
endinterface

// File: rtl/cofi_ctrl.sv
// cofi_ctrl: frame-aligned enable generator for the composite-blend stage.
// Measures active width/height on the pix_ce grid, classifies each frame as
// narrow (max width <= NARROW_MAX) or wide, and drives the blender enable from
// mode (0/3 off, 1 on, 2 auto). The enable only changes on the clk that samples
// a vblank rising edge, except while video is lost (watchdog expired), where it
// follows mode every clk.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    cofi_ctrl_if.slave: pix_ce, hblank, vblank, mode in;
//          enable, frame_valid, h_active, v_active out
// Optional: define COFI_CTRL_STATUS_EN to add frame_cnt (valid frame count,
// wraps) and en_changed (1-clk pulse on every enable toggle).
module cofi_ctrl #(
  parameter int unsigned HCNT_W        = 10,
  parameter int unsigned VCNT_W        = 10,
  parameter int unsigned NARROW_MAX    = 256,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned WD_W          = 24
) (
  input  logic       clk,
  input  logic       reset,
  cofi_ctrl_if.slave bus
);

  localparam int unsigned STAB_W = $clog2(STABLE_FRAMES + 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  state_t            state, state_n;

  logic              hb_d, vb_d;
  logic              hb_rise, vb_rise;
  logic [HCNT_W-1:0] hcnt, frame_w;
  logic [VCNT_W-1:0] vcnt;
  logic [HCNT_W-1:0] h_act_r;
  logic [VCNT_W-1:0] v_act_r;
  logic [WD_W-1:0]   wdog;
  logic [STAB_W-1:0] stab, stab_n;
  logic              cand, cand_n;
  logic              en_r, en_n;
  logic              fv_r, fv_n;
  logic              latch;
  logic              wd_expired;
  logic              frame_ok;
  logic              cls;
  logic              stab_full;

  assign hb_rise    = bus.pix_ce & bus.hblank & ~hb_d;
  assign vb_rise    = bus.pix_ce & bus.vblank & ~vb_d;
  // A vblank rise on the same clk rescues the watchdog, so it never expires
  // on a frame end.
  assign wd_expired = (&wdog) & ~vb_rise;
  assign frame_ok   = (frame_w != '0) && (vcnt != '0);
  assign cls        = (32'(frame_w) <= NARROW_MAX);
  assign stab_full  = (32'(stab) >= STABLE_FRAMES);

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    en_n    = en_r;
    stab_n  = stab;
    cand_n  = cand;
    fv_n    = fv_r;
    latch   = 1'b0;
    case (state)
      SYNC: begin
        if (vb_rise) state_n = MEASURE;
      end
      MEASURE: begin
        if (vb_rise) begin
          if (frame_ok) begin
            latch = 1'b1;
            fv_n  = 1'b1;
            if (cls == cand) begin
              if (!stab_full) stab_n = stab + STAB_W'(1);
            end else begin
              cand_n = cls;
              stab_n = STAB_W'(1);
            end
          end else begin
            fv_n   = 1'b0;
            stab_n = '0;
          end
          // Auto looks at the stability count after this frame is folded in.
          case (bus.mode)
            2'd1:    en_n = 1'b1;
            2'd2:    if (32'(stab_n) >= STABLE_FRAMES) en_n = cand_n;
            default: en_n = 1'b0;
          endcase
        end
      end
      LOST: begin
        en_n = (bus.mode == 2'd1);
        if (vb_rise) state_n = SYNC;
      end
      default: state_n = SYNC;
    endcase
    if ((state != LOST) && wd_expired) begin
      state_n = LOST;
      en_n    = (bus.mode == 2'd1);
      fv_n    = 1'b0;
      stab_n  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_r <= 1'b0;
      fv_r <= 1'b0;
      stab <= '0;
      cand <= 1'b0;
    end else begin
      en_r <= en_n;
      fv_r <= fv_n;
      stab <= stab_n;
      cand <= cand_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_d    <= 1'b0;
      vb_d    <= 1'b0;
      hcnt    <= '0;
      frame_w <= '0;
      vcnt    <= '0;
      wdog    <= '0;
      h_act_r <= '0;
      v_act_r <= '0;
    end else begin
      if (vb_rise)     wdog <= '0;
      else if (!(&wdog)) wdog <= wdog + WD_W'(1);

      if (bus.pix_ce) begin
        hb_d <= bus.hblank;
        vb_d <= bus.vblank;
      end

      // Frame end wins over a coincident hblank rise: the partial line is
      // dropped because everything clears here.
      if (vb_rise) begin
        hcnt    <= '0;
        frame_w <= '0;
        vcnt    <= '0;
      end else if (bus.pix_ce) begin
        if (hb_rise && !bus.vblank) begin
          if (hcnt != '0) begin
            if (hcnt > frame_w) frame_w <= hcnt;
            if (vcnt != '1)     vcnt    <= vcnt + VCNT_W'(1);
          end
          hcnt <= '0;
        end else if (!bus.hblank && !bus.vblank && (hcnt != '1)) begin
          hcnt <= hcnt + HCNT_W'(1);
        end
      end

      if (latch) begin
        h_act_r <= frame_w;
        v_act_r <= vcnt;
      end
    end
  end

  assign bus.enable      = en_r;
  assign bus.frame_valid = fv_r;
  assign bus.h_active    = h_act_r;
  assign bus.v_active    = v_act_r;

`ifdef COFI_CTRL_STATUS_EN
  logic [7:0] frame_cnt_r;
  logic       en_chg_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_r <= '0;
      en_chg_r    <= 1'b0;
    end else begin
      if (latch) frame_cnt_r <= frame_cnt_r + 8'd1;
      en_chg_r <= (en_n != en_r);
    end
  end

  assign bus.frame_cnt  = frame_cnt_r;
  assign bus.en_changed = en_chg_r;
`endif

endmodule
